// File: rtl/exec_ifd_responder_if.sv
// Memory port between the execution responder and a simple synchronous memory.
// Read data returns exactly one cycle after the read strobe.
interface exec_ifd_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/exec_ifd_responder.sv
// Execution-side responder for the IFD decoded-instruction interface.
// Owns PC, AC and Link; runs one-hot memory-reference and op7 opcodes.
module exec_ifd_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [DATA_WIDTH+5:0]   pdp_mem_opcode,
    input  logic [21:0]             pdp_op7_opcode,
    output logic                    stall,
    output logic [ADDR_WIDTH-1:0]   PC_value,
    output logic [DATA_WIDTH-1:0]   ac_value,
    output logic                    link_value,
    output logic                    instr_done,
    output logic                    illegal_op,
    output logic                    halted,
    exec_ifd_responder_if.master    mem
);
    localparam int M_JMP = 0, M_JMS = 1, M_DCA = 2;
    localparam int M_ISZ = 3, M_TAD = 4, M_AND = 5;
    localparam int O_CLA2 = 0, O_SPA = 1, O_SMA = 2, O_SNA = 3;
    localparam int O_SZA = 4, O_SZL = 5, O_SNL = 6, O_SKP = 7;
    localparam int O_OSR = 8, O_HLT = 9, O_CLA_CLL = 10, O_CLA1 = 11;
    localparam int O_CLL = 12, O_CIA = 13, O_CMA = 14, O_CML = 15;
    localparam int O_RTR = 16, O_RAR = 17, O_RTL = 18, O_RAL = 19;
    localparam int O_IAC = 20, O_NOP = 21;

    typedef enum logic [2:0] {IDLE, RD_WAIT, EXEC, WB, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, ia_q, ia_d, addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d, wdata_q, wdata_d;
    logic                  lk_q, lk_d, halt_q, halt_d, armed_q, armed_d;
    logic                  stall_q, stall_d, rd_q, rd_d, wr_q, wr_d;
    logic                  done_q, done_d, ill_q, ill_d;
    logic [5:0]            mop_q, mop_d;
    logic [21:0]           op7_q, op7_d;

    logic [5:0]            code;
    logic [ADDR_WIDTH-1:0] maddr, pc_inc, pc_skip;
    logic                  mem_nz, op_nz, bus_zero, bad;
    logic [DATA_WIDTH:0]   lac, tad_sum, lac_inc;
    logic [DATA_WIDTH-1:0] isz_val;

    assign code     = pdp_mem_opcode[DATA_WIDTH+5:DATA_WIDTH];
    assign maddr    = pdp_mem_opcode[ADDR_WIDTH-1:0];
    assign mem_nz   = |pdp_mem_opcode;
    assign op_nz    = |pdp_op7_opcode;
    assign bus_zero = !mem_nz && !op_nz;
    assign bad      = (mem_nz && op_nz)
                    || (mem_nz && !$onehot(code))
                    || (op_nz && !$onehot(pdp_op7_opcode));
    assign pc_inc   = pc_q + ADDR_WIDTH'(1);
    assign pc_skip  = pc_q + ADDR_WIDTH'(2);
    assign lac      = {lk_q, ac_q};
    assign lac_inc  = lac + (DATA_WIDTH+1)'(1);
    assign tad_sum  = lac + {1'b0, mem.mem_rdata};
    assign isz_val  = mem.mem_rdata + DATA_WIDTH'(1);

    // Next-state and datapath decisions for the execution FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ac_d    = ac_q;
        lk_d    = lk_q;
        halt_d  = halt_q;
        armed_d = armed_q | bus_zero;
        stall_d = stall_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        mop_d   = mop_q;
        op7_d   = op7_q;
        ia_d    = ia_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (armed_q && !bus_zero) begin
                    armed_d = 1'b0;
                    stall_d = 1'b1;
                    ia_d    = maddr;
                    base_d  = base_addr;
                    if (bad) begin
                        ill_d   = 1'b1;
                        mop_d   = '0;
                        op7_d   = 22'(1) << O_NOP;
                        done_d  = 1'b1;
                        state_d = EXEC;
                    end else if (mem_nz) begin
                        mop_d = code;
                        op7_d = '0;
                        unique case (1'b1)
                            code[M_JMP]: begin
                                done_d  = 1'b1;
                                state_d = EXEC;
                            end
                            code[M_DCA]: begin
                                wr_d    = 1'b1;
                                addr_d  = maddr;
                                wdata_d = ac_q;
                                done_d  = 1'b1;
                                state_d = WB;
                            end
                            code[M_JMS]: begin
                                wr_d    = 1'b1;
                                addr_d  = maddr;
                                wdata_d = DATA_WIDTH'(pc_inc);
                                done_d  = 1'b1;
                                state_d = WB;
                            end
                            default: begin
                                rd_d    = 1'b1;
                                addr_d  = maddr;
                                state_d = RD_WAIT;
                            end
                        endcase
                    end else begin
                        mop_d   = '0;
                        op7_d   = pdp_op7_opcode;
                        done_d  = 1'b1;
                        state_d = EXEC;
                    end
                end
            end
            RD_WAIT: begin
                done_d  = !mop_q[M_ISZ];
                state_d = EXEC;
            end
            EXEC: begin
                state_d = IDLE;
                stall_d = 1'b0;
                pc_d    = pc_inc;
                if (mop_q[M_ISZ]) begin
                    wr_d    = 1'b1;
                    addr_d  = ia_q;
                    wdata_d = isz_val;
                    done_d  = 1'b1;
                    pc_d    = (isz_val == '0) ? pc_skip : pc_inc;
                    stall_d = 1'b1;
                    state_d = WB;
                end else if (mop_q[M_JMP]) begin
                    pc_d = ia_q;
                end else if (mop_q[M_AND]) begin
                    ac_d = ac_q & mem.mem_rdata;
                end else if (mop_q[M_TAD]) begin
                    {lk_d, ac_d} = tad_sum;
                end else begin
                    unique case (1'b1)
                        op7_q[O_CLA1], op7_q[O_CLA2]: ac_d = '0;
                        op7_q[O_CLL]: lk_d = 1'b0;
                        op7_q[O_CLA_CLL]: begin
                            ac_d = '0;
                            lk_d = 1'b0;
                        end
                        op7_q[O_CMA]: ac_d = ~ac_q;
                        op7_q[O_CML]: lk_d = ~lk_q;
                        op7_q[O_IAC]: {lk_d, ac_d} = lac_inc;
                        op7_q[O_CIA]: ac_d = ~ac_q + DATA_WIDTH'(1);
                        op7_q[O_RAL]: {lk_d, ac_d} = {lac[DATA_WIDTH-1:0], lac[DATA_WIDTH]};
                        op7_q[O_RAR]: {lk_d, ac_d} = {lac[0], lac[DATA_WIDTH:1]};
                        op7_q[O_RTL]: {lk_d, ac_d} = {lac[DATA_WIDTH-2:0], lac[DATA_WIDTH:DATA_WIDTH-1]};
                        op7_q[O_RTR]: {lk_d, ac_d} = {lac[1:0], lac[DATA_WIDTH:2]};
                        op7_q[O_SMA]: if (ac_q[DATA_WIDTH-1]) pc_d = pc_skip;
                        op7_q[O_SPA]: if (!ac_q[DATA_WIDTH-1]) pc_d = pc_skip;
                        op7_q[O_SZA]: if (ac_q == '0) pc_d = pc_skip;
                        op7_q[O_SNA]: if (ac_q != '0) pc_d = pc_skip;
                        op7_q[O_SNL]: if (lk_q) pc_d = pc_skip;
                        op7_q[O_SZL]: if (!lk_q) pc_d = pc_skip;
                        op7_q[O_SKP]: pc_d = pc_skip;
                        op7_q[O_HLT]: begin
                            halt_d  = 1'b1;
                            stall_d = 1'b1;
                            state_d = DONE;
                        end
                        default: ;
                    endcase
                end
            end
            WB: begin
                state_d = IDLE;
                stall_d = 1'b0;
                if (mop_q[M_DCA]) begin
                    ac_d = '0;
                    pc_d = pc_inc;
                end else if (mop_q[M_JMS]) begin
                    pc_d = ia_q + ADDR_WIDTH'(1);
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDRESS;
            ac_q    <= '0;
            lk_q    <= 1'b0;
            halt_q  <= 1'b0;
            armed_q <= 1'b1;
            stall_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            mop_q   <= '0;
            op7_q   <= '0;
            ia_q    <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            lk_q    <= lk_d;
            halt_q  <= halt_d;
            armed_q <= armed_d;
            stall_q <= stall_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            mop_q   <= mop_d;
            op7_q   <= op7_d;
            ia_q    <= ia_d;
            base_q  <= base_d;
        end
    end

    assign stall         = stall_q;
    assign PC_value      = pc_q;
    assign ac_value      = ac_q;
    assign link_value    = lk_q;
    assign instr_done    = done_q;
    assign illegal_op    = ill_q;
    assign halted        = halt_q;
    assign mem.mem_rd    = rd_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_exec_ifd_responder.sv
// Directed bench for exec_ifd_responder with a small synchronous memory.
// Expected PC/AC/Link values are worked out by hand per instruction.
module tb_exec_ifd_responder;
    localparam int M_JMP = 0, M_JMS = 1, M_DCA = 2;
    localparam int M_ISZ = 3, M_TAD = 4, M_AND = 5;
    localparam int O_SMA = 2, O_SZA = 4, O_SZL = 5, O_SNL = 6;
    localparam int O_HLT = 9, O_CLA_CLL = 10, O_CLA1 = 11, O_CIA = 13;
    localparam int O_CMA = 14, O_CML = 15, O_RAR = 17, O_RTL = 18;
    localparam int O_RAL = 19, O_IAC = 20, O_NOP = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] base_addr;
    logic [17:0] mop;
    logic [21:0] op7;
    logic        stall, link_value, instr_done, illegal_op, halted;
    logic [11:0] PC_value, ac_value;
    logic [11:0] mem_arr [0:4095];

    int errs = 0;
    int checks = 0;
    int lat, rda, wra, dn, il, cnt;

    exec_ifd_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) bus ();

    exec_ifd_responder dut (
        .clk            (clk),
        .reset          (reset),
        .base_addr      (base_addr),
        .pdp_mem_opcode (mop),
        .pdp_op7_opcode (op7),
        .stall          (stall),
        .PC_value       (PC_value),
        .ac_value       (ac_value),
        .link_value     (link_value),
        .instr_done     (instr_done),
        .illegal_op     (illegal_op),
        .halted         (halted),
        .mem            (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem_arr[bus.mem_addr];
        if (bus.mem_wr) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mref(input int c, input logic [11:0] a);
        logic [5:0] cd;
        cd = 6'd1 << c;
        return {cd, a};
    endfunction

    function automatic logic [21:0] o7(input int b);
        return 22'd1 << b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arch(input string tag, input logic [11:0] pc,
                        input logic [11:0] ac, input logic l);
        chk({tag, ".pc"}, PC_value, pc);
        chk({tag, ".ac"}, ac_value, ac);
        chk({tag, ".l"}, link_value, l);
    endtask

    // Present an opcode, wait for stall to drop, hold extra cycles, then clear.
    task automatic run(input logic [17:0] m, input logic [21:0] o, input int hold);
        lat = -1; rda = -1; wra = -1; dn = 0; il = 0;
        mop = m;
        op7 = o;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.mem_rd && rda < 0) rda = c;
            if (bus.mem_wr && wra < 0) wra = c;
            dn += int'(instr_done);
            il += int'(illegal_op);
            if (!stall) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("stall_timeout", 32'(lat), 32'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            dn += int'(instr_done);
            il += int'(illegal_op);
        end
        mop = '0;
        op7 = '0;
        step();
        dn += int'(instr_done);
        il += int'(illegal_op);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_arr[i] = 12'o0;
        mem_arr[1]     = 12'o0707;
        mem_arr[3]     = 12'o0001;
        mem_arr[5]     = 12'o7777;
        mem_arr[6]     = 12'o0005;
        mem_arr[12'o20] = 12'o7777;
        mem_arr[12'o21] = 12'o0100;
        base_addr = 12'o1000;
        mop = '0;
        op7 = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        arch("reset", 12'o200, 12'o0, 1'b0);
        chk("reset.stall", stall, 0);
        chk("reset.halted", halted, 0);

        run('0, o7(O_CLA1), 0);
        run('0, o7(O_CMA), 0);
        arch("cma", 12'o202, 12'o7777, 1'b0);

        run(mref(M_AND, 12'd1), '0, 0);
        chk("and.rd_at", rda, 1);
        chk("and.lat", lat, 3);
        chk("and.done", dn, 1);
        arch("and", 12'o203, 12'o0707, 1'b0);

        run('0, o7(O_CLA1), 0);
        run('0, o7(O_CMA), 0);
        run(mref(M_TAD, 12'd3), '0, 0);
        chk("tad.lat", lat, 3);
        arch("tad", 12'o206, 12'o0, 1'b1);

        run(mref(M_ISZ, 12'd5), '0, 0);
        chk("isz.rd_at", rda, 1);
        chk("isz.wr_at", wra, 3);
        chk("isz.lat", lat, 4);
        chk("isz.mem", mem_arr[5], 12'o0);
        chk("isz.pc", PC_value, 12'o210);

        run(mref(M_JMS, 12'd9), '0, 0);
        chk("jms.wr_at", wra, 1);
        chk("jms.lat", lat, 2);
        chk("jms.mem", mem_arr[9], 12'o211);
        chk("jms.pc", PC_value, 12'o012);

        run(mref(M_JMP, 12'd12), '0, 0);
        chk("jmp.lat", lat, 2);
        chk("jmp.pc", PC_value, 12'o014);

        run(mref(M_TAD, 12'd6), '0, 0);
        arch("tad5", 12'o015, 12'o0005, 1'b1);
        run(mref(M_DCA, 12'd7), '0, 0);
        chk("dca.lat", lat, 2);
        chk("dca.mem", mem_arr[7], 12'o0005);
        arch("dca", 12'o016, 12'o0, 1'b1);

        run('0, o7(O_CLA_CLL), 0);
        arch("clacll", 12'o017, 12'o0, 1'b0);
        run('0, o7(O_SZA), 0);
        chk("sza.pc", PC_value, 12'o021);
        run('0, o7(O_IAC), 0);
        run('0, o7(O_RAL), 0);
        arch("ral", 12'o023, 12'o0002, 1'b0);
        run('0, o7(O_CIA), 0);
        arch("cia", 12'o024, 12'o7776, 1'b0);
        run('0, o7(O_SMA), 0);
        chk("sma.pc", PC_value, 12'o026);
        run('0, o7(O_RTL), 0);
        arch("rtl", 12'o027, 12'o7771, 1'b1);
        run('0, o7(O_CML), 0);
        run('0, o7(O_RAR), 0);
        arch("rar", 12'o031, 12'o3774, 1'b1);
        run('0, o7(O_SNL), 0);
        chk("snl.pc", PC_value, 12'o033);
        run('0, o7(O_SZL), 0);
        chk("szl.pc", PC_value, 12'o034);

        run('0, o7(O_NOP), 1);
        chk("hold.done", dn, 1);
        chk("hold.pc", PC_value, 12'o035);

        op7 = o7(O_IAC);
        cnt = 0;
        repeat (2) begin
            step();
            cnt += int'(instr_done);
        end
        chk("iac.stall", stall, 0);
        op7 = o7(O_CML);
        repeat (3) begin
            step();
            cnt += int'(instr_done);
        end
        chk("noarm.done", cnt, 1);
        chk("noarm.stall", stall, 0);
        arch("noarm", 12'o036, 12'o3775, 1'b1);
        op7 = '0;
        step();
        run('0, o7(O_CML), 0);
        arch("cml2", 12'o037, 12'o3775, 1'b0);

        run(mref(M_JMP, 12'o0), o7(O_IAC), 0);
        chk("ill_both.pulse", il, 1);
        arch("ill_both", 12'o040, 12'o3775, 1'b0);
        run({6'b000011, 12'd1}, '0, 0);
        chk("ill_code.pulse", il, 1);
        chk("ill_code.rd", rda, 32'hFFFF_FFFF);
        chk("ill_code.wr", wra, 32'hFFFF_FFFF);
        chk("ill_code.mem", mem_arr[1], 12'o0707);
        arch("ill_code", 12'o041, 12'o3775, 1'b0);

        run(mref(M_JMP, 12'o7776), '0, 0);
        run(mref(M_ISZ, 12'o20), '0, 0);
        chk("isz_wrap.mem", mem_arr[12'o20], 12'o0);
        chk("isz_wrap.pc", PC_value, 12'o0);
        run(mref(M_JMP, 12'o7777), '0, 0);
        run('0, o7(O_NOP), 0);
        chk("pc_wrap", PC_value, 12'o0);

        mop = mref(M_ISZ, 12'o21);
        step();
        chk("rst_isz.rd", bus.mem_rd, 1);
        step();
        reset = 1'b1;
        mop = '0;
        step();
        chk("rst_isz.wr", bus.mem_wr, 0);
        chk("rst_isz.stall", stall, 0);
        chk("rst_isz.pc", PC_value, 12'o200);
        reset = 1'b0;
        step();
        chk("rst_isz.mem", mem_arr[12'o21], 12'o0100);

        op7 = o7(O_HLT);
        step();
        chk("hlt.stall", stall, 1);
        op7 = o7(O_IAC);
        cnt = 0;
        repeat (100) begin
            step();
            if (!stall) cnt++;
        end
        chk("hlt.stall_lows", cnt, 0);
        chk("hlt.halted", halted, 1);
        arch("hlt", 12'o201, 12'o0, 1'b0);
        op7 = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("hlt_rst.stall", stall, 0);
        chk("hlt_rst.halted", halted, 0);
        chk("hlt_rst.pc", PC_value, 12'o200);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/exec_ifd_responder.md
Name: exec_ifd_responder

Overview:
Execution-side responder for the decoded-instruction interface that the IFD stage drives. Accepts one-hot memory-reference or op7 opcodes, asserts stall while executing, and performs memory accesses over a simple synchronous memory port. Owns PC, AC and Link, and reports PC_value back to the IFD. Serves as the reference execution unit for IFD unit-level tests and as the first cut of the real EX stage.

Parameters:
ADDR_WIDTH, 12, address/PC width
DATA_WIDTH, 12, memory word and AC width
START_ADDRESS, 12'o200, PC value after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
base_addr  in  ADDR_WIDTH  IFD base address, captured with each instruction (informational only)
pdp_mem_opcode  in  6+DATA_WIDTH  {one-hot code[5:0], address}; code bit0 JMP, 1 JMS, 2 DCA, 3 ISZ, 4 TAD, 5 AND
pdp_op7_opcode  in  22  one-hot; bit0 CLA2, 1 SPA, 2 SMA, 3 SNA, 4 SZA, 5 SZL, 6 SNL, 7 SKP, 8 OSR, 9 HLT, 10 CLA_CLL, 11 CLA1, 12 CLL, 13 CIA, 14 CMA, 15 CML, 16 RTR, 17 RAR, 18 RTL, 19 RAL, 20 IAC, 21 NOP
stall  out  1  high while busy or halted
PC_value  out  ADDR_WIDTH  current PC
ac_value  out  DATA_WIDTH  accumulator
link_value  out  1  link bit
mem_rd  out  1  read strobe, one cycle
mem_wr  out  1  write strobe, one cycle
mem_addr  out  ADDR_WIDTH  access address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after mem_rd
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  one-cycle pulse when an illegal encoding is accepted
halted  out  1  sticky after HLT

Behaviour:
- Reset (synchronous; takes priority in any state): PC=START_ADDRESS, AC=0, L=0, stall=0, halted=0, all strobes/pulses 0, armed=1, state IDLE. A reset mid-instruction abandons it with no memory write.
- States: IDLE, RD_WAIT, EXEC, WB, DONE. stall is registered; it is 1 in every state except IDLE and stays 1 while halted.
- Accept in IDLE when armed=1 and either opcode bus is nonzero. Acceptance clears armed; armed re-sets only after a cycle in which both buses are all zero. This prevents re-executing an opcode that the IFD holds for one cycle after stall falls.
- Illegal encodings: more than one hot bit in a bus, or both buses nonzero. Pulse illegal_op, execute as NOP (PC+1).
- Timing, with T = acceptance cycle (stall high from T+1):
  - op7, JMP: EXEC at T+1; stall low at T+2.
  - DCA, JMS: mem_wr at T+1; stall low at T+2.
  - AND, TAD: mem_rd at T+1, data at T+2; stall low at T+3.
  - ISZ: mem_rd at T+1, mem_wr at T+3; stall low at T+4.
  - instr_done pulses in the last stall-high cycle.
- Memory-reference semantics (address = opcode address field; all arithmetic mod 2^12):
  - AND: AC &= M.
  - TAD: {L,AC} = {L,AC} + M; a carry out of AC complements L.
  - ISZ: M = M+1; PC += 2 if the result is 0, else PC += 1.
  - DCA: M = AC; AC = 0.
  - JMS: M = PC+1; PC = addr+1.
  - JMP: PC = addr.
  - All other instructions: PC += 1.
- op7 semantics:
  - CLA1, CLA2: AC = 0.
  - CLL: L = 0.
  - CLA_CLL: both AC = 0 and L = 0.
  - CMA: AC = ~AC. CML: L = ~L. IAC: {L,AC} += 1. CIA: AC = -AC, L unchanged.
  - RAL, RAR: rotate {L,AC} by 1. RTL, RTR: rotate {L,AC} by 2.
  - Skips add 1 extra to PC when true. SMA: AC[11]. SZA: AC==0. SNL: L. SPA: !AC[11]. SNA: AC!=0. SZL: !L. SKP: always.
  - OSR, NOP: no effect.
  - HLT: halted=1, PC += 1, stall held high until reset.
- PC wraps from 12'o7777 to 0. ISZ or skip with PC=12'o7776 gives PC=0.
- mem_addr and mem_wdata are valid only with a strobe; otherwise they hold their last value.

Test Plan:
- Reset, then AND addr 1 with M[1]=12'o0707, AC=12'o7777 -> mem_rd at T+1, AC=12'o0707, PC=12'o201, stall low at T+3, one instr_done.
- TAD addr 3 with M[3]=12'o0001, AC=12'o7777, L=0 -> AC=0, L=1. ISZ addr 5 with M[5]=12'o7777 -> M[5]=0, PC advances by 2.
- JMS addr 9 at PC=12'o200 -> M[9]=12'o201, PC=12'o012. JMP addr 12 -> PC=12'o014. DCA addr 7 with AC=5 -> M[7]=5, AC=0.
- IFD holds opcode one cycle after stall falls, then clears -> instruction executes exactly once (instr_done count = 1); next opcode is accepted only after the zero cycle.
- mem and op7 buses both nonzero, or mem code 6'b000011 -> illegal_op pulse, PC += 1, AC/L and memory unchanged.
- HLT -> halted=1, stall stays 1 for 100 cycles while new opcodes are ignored; reset asserted mid-ISZ -> no mem_wr, PC=12'o200, stall=0 next cycle.
